// File: rtl/toccata_pkg.sv
// Shared types for the Toccata volume sequencer: attenuation type, its ceiling,
// and the per-channel ramp states.
package toccata_pkg;

   typedef logic [5:0] atten_t;

   localparam atten_t ATTEN_MAX = 6'd63;

   typedef enum logic [1:0] {
      MUTED = 2'd0,
      RAMP  = 2'd1,
      IDLE  = 2'd2,
      FADE  = 2'd3
   } ramp_state_e;

endpackage

// File: rtl/toccata_volume_ramp_chan.sv
// One channel of the volume sequencer: slews attenuation by one step per step_en
// and sequences soft mute (fade then hard mute) and unmute (release then fade in).
module toccata_volume_ramp_chan
   import toccata_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   step_en,
   input  atten_t tgt_atten,
   input  logic   tgt_mute,
   output atten_t att,
   output logic   mute,
   output logic   active
);

   ramp_state_e state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= MUTED;
         att   <= ATTEN_MAX;
         mute  <= 1'b1;
      end else if (step_en) begin
         case (state)
            MUTED: begin
               // Release the hard mute first; the fade-in starts on the next step.
               if (!tgt_mute) begin
                  mute  <= 1'b0;
                  state <= RAMP;
               end
            end
            RAMP: begin
               if (tgt_mute)               state <= FADE;
               else if (att > tgt_atten)   att   <= att - 6'd1;
               else if (att < tgt_atten)   att   <= att + 6'd1;
               else                        state <= IDLE;
            end
            IDLE: begin
               if (tgt_mute)                state <= FADE;
               else if (tgt_atten != att)   state <= RAMP;
            end
            FADE: begin
               if (!tgt_mute)               state <= RAMP;
               else if (att < ATTEN_MAX)    att   <= att + 6'd1;
               else begin
                  mute  <= 1'b1;
                  state <= MUTED;
               end
            end
            default: state <= MUTED;
         endcase
      end
   end

   assign active = (state == RAMP) || (state == FADE);

endmodule

// File: rtl/toccata_volume_ramp.sv
// Stereo volume sequencer: shared sample-tick divider producing step_en, two
// independent channel sequencers, and the combined busy flag.
module toccata_volume_ramp
   import toccata_pkg::*;
#(
   parameter int STEP_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_tick,
   input  logic [5:0] target_atten_left,
   input  logic       target_mute_left,
   input  logic [5:0] target_atten_right,
   input  logic       target_mute_right,
   output logic [5:0] attenuation_left,
   output logic       mute_left,
   output logic [5:0] attenuation_right,
   output logic       mute_right,
   output logic       busy
);

   localparam int NUM_CHAN = 2;
   localparam int DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   logic [DIV_W-1:0]              div_cnt;
   logic                          step_en;
   logic [NUM_CHAN-1:0][5:0]      tgt_att;
   logic [NUM_CHAN-1:0][5:0]      att;
   logic [NUM_CHAN-1:0]           tgt_mute;
   logic [NUM_CHAN-1:0]           mute;
   logic [NUM_CHAN-1:0]           active;

   assign step_en = sample_tick && (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst)               div_cnt <= '0;
      else if (sample_tick)  div_cnt <= step_en ? '0 : div_cnt + DIV_W'(1);
   end

   assign tgt_att[0]  = target_atten_left;
   assign tgt_att[1]  = target_atten_right;
   assign tgt_mute[0] = target_mute_left;
   assign tgt_mute[1] = target_mute_right;

   for (genvar ch = 0; ch < NUM_CHAN; ch++) begin : g_chan
      toccata_volume_ramp_chan u_chan (
         .clk       (clk),
         .rst       (rst),
         .step_en   (step_en),
         .tgt_atten (tgt_att[ch]),
         .tgt_mute  (tgt_mute[ch]),
         .att       (att[ch]),
         .mute      (mute[ch]),
         .active    (active[ch])
      );
   end

   assign attenuation_left  = att[0];
   assign mute_left         = mute[0];
   assign attenuation_right = att[1];
   assign mute_right        = mute[1];
   assign busy              = |active;

endmodule

// File: tb/tb_toccata_volume_ramp.sv
// Randomized check of toccata_volume_ramp (STEP_DIV=4 and STEP_DIV=1) against a
// cycle-level behavioural model, plus directed checks of the power-up ramp.
module tb_toccata_volume_ramp;

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_tick;
   logic [5:0] tgt_l, tgt_r;
   logic       tm_l, tm_r;

   logic [5:0] att_l [2];
   logic [5:0] att_r [2];
   logic       mute_l [2];
   logic       mute_r [2];
   logic       busy [2];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   toccata_volume_ramp #(.STEP_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .sample_tick(sample_tick),
      .target_atten_left(tgt_l), .target_mute_left(tm_l),
      .target_atten_right(tgt_r), .target_mute_right(tm_r),
      .attenuation_left(att_l[0]), .mute_left(mute_l[0]),
      .attenuation_right(att_r[0]), .mute_right(mute_r[0]),
      .busy(busy[0])
   );

   toccata_volume_ramp #(.STEP_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .sample_tick(sample_tick),
      .target_atten_left(tgt_l), .target_mute_left(tm_l),
      .target_atten_right(tgt_r), .target_mute_right(tm_r),
      .attenuation_left(att_l[1]), .mute_left(mute_l[1]),
      .attenuation_right(att_r[1]), .mute_right(mute_r[1]),
      .busy(busy[1])
   );

   // Reference model: [dut][channel]; mode 0=muted 1=ramping 2=settled 3=fading
   int    divs [2] = '{4, 1};
   string nm   [2] = '{"div4", "div1"};
   int    m_att  [2][2];
   int    m_mute [2][2];
   int    m_mode [2][2];
   int    m_cnt  [2];

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chan_step(input int d, input int c, input int tgt, input int tm);
      case (m_mode[d][c])
         0: if (tm == 0) begin m_mute[d][c] = 0; m_mode[d][c] = 1; end
         1: begin
            if (tm != 0)                 m_mode[d][c] = 3;
            else if (m_att[d][c] != tgt) m_att[d][c] += (tgt > m_att[d][c]) ? 1 : -1;
            else                         m_mode[d][c] = 2;
         end
         2: begin
            if (tm != 0)                 m_mode[d][c] = 3;
            else if (m_att[d][c] != tgt) m_mode[d][c] = 1;
         end
         default: begin
            if (tm == 0)                 m_mode[d][c] = 1;
            else if (m_att[d][c] < 63)   m_att[d][c]++;
            else begin m_mute[d][c] = 1; m_mode[d][c] = 0; end
         end
      endcase
   endtask

   task automatic model_edge();
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_cnt[d] = 0;
            for (int c = 0; c < 2; c++) begin
               m_att[d][c] = 63; m_mute[d][c] = 1; m_mode[d][c] = 0;
            end
         end else if (sample_tick) begin
            m_cnt[d]++;
            if (m_cnt[d] == divs[d]) begin
               m_cnt[d] = 0;
               chan_step(d, 0, int'(tgt_l), int'(tm_l));
               chan_step(d, 1, int'(tgt_r), int'(tm_r));
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int d = 0; d < 2; d++) begin
         int exp_busy;
         exp_busy = (m_mode[d][0] % 2 == 1 || m_mode[d][1] % 2 == 1) ? 1 : 0;
         chk({nm[d], ".att_l"},  int'(att_l[d]),  m_att[d][0]);
         chk({nm[d], ".mute_l"}, int'(mute_l[d]), m_mute[d][0]);
         chk({nm[d], ".att_r"},  int'(att_r[d]),  m_att[d][1]);
         chk({nm[d], ".mute_r"}, int'(mute_r[d]), m_mute[d][1]);
         chk({nm[d], ".busy"},   int'(busy[d]),   exp_busy);
      end
   endtask

   // One clock: model follows the edge, outputs sampled 1 time unit later.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      rst = 1'b1; sample_tick = 1'b1;
      tgt_l = 6'd0; tgt_r = 6'd0; tm_l = 1'b0; tm_r = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      chk("reset.att_l", int'(att_l[0]), 63);
      chk("reset.mute_l", int'(mute_l[0]), 1);
      chk("reset.busy", int'(busy[0]), 0);

      // Power-up fade-in with a tick every cycle.
      rst = 1'b0;
      for (int t = 1; t <= 260; t++) begin
         cycle();
         if (t == 3)   chk("pwrup.mute_before_t4", int'(mute_l[0]), 1);
         if (t == 4)   chk("pwrup.mute_after_t4", int'(mute_l[0]), 0);
         if (t == 255) chk("pwrup.att_t255", int'(att_l[0]), 1);
         if (t == 256) chk("pwrup.att_t256", int'(att_l[0]), 0);
         if (t == 259) chk("pwrup.busy_t259", int'(busy[0]), 1);
         if (t == 260) chk("pwrup.busy_t260", int'(busy[0]), 0);
      end

      // Random targets, mute toggles, sparse and back-to-back ticks, rare resets.
      for (int i = 0; i < 8000; i++) begin
         sample_tick = ($urandom_range(0, 2) != 0);
         rst = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 15) == 0) tgt_l = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 15) == 0) tgt_r = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 63) == 0) tm_l = ~tm_l;
         if ($urandom_range(0, 63) == 0) tm_r = ~tm_r;
         if ($urandom_range(0, 31) == 0) begin
            tgt_r = tgt_l; tm_r = tm_l;
         end
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
